// File: rtl/core_pkg.sv
// core_pkg -- shared types and constants for the instruction fetch sequencer.
//
// Contents:
//   INST_W          instruction word width
//   PC_W_DEF        default PC / memory address width (word addressed)
//   RESET_PC_DEF    default PC value loaded at reset
//   TIMEOUT_DEF     default fetch watchdog length in cycles
//   state_t         sequencer state encoding (HALT is only reachable when the
//                   fetch watchdog is built in)
package core_pkg;

  localparam int          INST_W       = 16;
  localparam int          PC_W_DEF     = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam int          TIMEOUT_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

endpackage

// File: rtl/inst_fetch_seq_if.sv
// inst_fetch_seq_if -- instruction memory read bus.
//
// Handshake: the master raises o_mem_req with o_mem_addr and holds both
// stable until it samples i_mem_ack=1 on a rising clock edge; i_mem_data is
// only meaningful in that ack cycle. The transfer completes in the ack cycle
// (zero-wait memory may ack in the very first request cycle). An ack while
// o_mem_req is low carries no transfer and is ignored by the master.
//
// Signals:
//   o_mem_req   master -> slave  read request
//   o_mem_addr  master -> slave  word address
//   i_mem_ack   slave  -> master data valid this cycle
//   i_mem_data  slave  -> master instruction word
//
// Modports: master (fetch sequencer), slave (instruction memory).
interface inst_fetch_seq_if #(
  parameter int PC_W = 16
);
  import core_pkg::*;

  logic              o_mem_req;
  logic [PC_W-1:0]   o_mem_addr;
  logic              i_mem_ack;
  logic [INST_W-1:0] i_mem_data;

  modport master (
    output o_mem_req,
    output o_mem_addr,
    input  i_mem_ack,
    input  i_mem_data
  );

  modport slave (
    input  o_mem_req,
    input  o_mem_addr,
    output i_mem_ack,
    output i_mem_data
  );

endinterface

// File: rtl/pc_reg.sv
// pc_reg -- program counter register.
//
// Ports:
//   clk       core clock, rising edge
//   rst_n     synchronous active-low reset, loads RESET_PC
//   inc_en    advance PC by one word (wraps modulo 2^PC_W)
//   load_en   load load_val (takes priority over inc_en)
//   load_val  load target
//   pc        current PC
module pc_reg #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_en,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;

  // The add is kept at PC_W bits so the all-ones address rolls to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load_en) begin
      pc_q <= load_val;
    end else if (inc_en) begin
      pc_q <= pc_q + PC_W'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/inst_fetch_seq.sv
// inst_fetch_seq -- instruction fetch / decode sequencer of the 16-bit RISC
// core. Owns the PC, reads one instruction at a time from instruction memory
// and walks it through DECODE, EXECUTE and WRITEBACK with one-cycle enables.
// Branch redirects are applied on the edge leaving WRITEBACK.
//
// Build option:
//   FETCH_TIMEOUT_EN  when defined, a watchdog counts FETCH cycles without
//                     ack; after TIMEOUT of them o_fault sets (sticky), the
//                     request drops and the sequencer parks in HALT until
//                     reset. When undefined, FETCH waits forever and o_fault
//                     is constant 0.
//
// Ports:
//   i_clk         core clock, all state on rising edge
//   i_rst_n       synchronous active-low reset
//   i_run         allow new fetches; 0 parks in IDLE at the next boundary
//   mem           instruction memory bus (master side)
//   o_inst        latched instruction, stable DECODE through WRITEBACK
//   o_dec_en      decoder enable, one cycle per instruction
//   o_alu_en      ALU enable, one cycle per instruction
//   o_wb_en       register writeback enable, one cycle per instruction
//   i_branch_en   take branch (only looked at in WRITEBACK)
//   i_branch_tgt  branch target word address
//   o_pc          current PC
//   o_fault       sticky fetch fault
//   o_dbg_state   current sequencer state
module inst_fetch_seq
  import core_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int              TIMEOUT  = TIMEOUT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  inst_fetch_seq_if.master   mem,
  output logic [INST_W-1:0]  o_inst,
  output logic               o_dec_en,
  output logic               o_alu_en,
  output logic               o_wb_en,
  input  logic               i_branch_en,
  input  logic [PC_W-1:0]    i_branch_tgt,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_fault,
  output state_t             o_dbg_state
);

  state_t            state_q;
  state_t            state_d;
  logic              mem_req;
  logic              inst_load;
  logic              pc_inc;
  logic              pc_load;
  logic [INST_W-1:0] inst_q;
  logic [PC_W-1:0]   pc;
  logic              timeout_hit;

  // ---------------------------------------------------------------------
  // Fetch watchdog
  // ---------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt_q;
  logic             fault_q;

  // The counter sits at zero outside FETCH, so every FETCH entry starts a
  // fresh count. The hit fires on the TIMEOUT-th unacknowledged cycle.
  assign timeout_hit = (state_q == ST_FETCH) && !mem.i_mem_ack &&
                       (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      if ((state_q == ST_FETCH) && !mem.i_mem_ack && !timeout_hit) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end else begin
        wait_cnt_q <= '0;
      end
      if (timeout_hit) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign o_fault = fault_q;
`else
  assign timeout_hit = 1'b0;
  // TIMEOUT has no effect without the watchdog; this compare is constant 0.
  assign o_fault     = (TIMEOUT < 0);
`endif

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    inst_load = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    o_dec_en  = 1'b0;
    o_alu_en  = 1'b0;
    o_wb_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem.i_mem_ack) begin
          inst_load = 1'b1;
          state_d   = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_HALT;
        end
      end

      ST_DECODE: begin
        o_dec_en = 1'b1;
        state_d  = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        o_alu_en = 1'b1;
        state_d  = ST_WRITEBACK;
      end

      ST_WRITEBACK: begin
        o_wb_en = 1'b1;
        pc_load = i_branch_en;
        pc_inc  = !i_branch_en;
        state_d = i_run ? ST_FETCH : ST_IDLE;
      end

`ifdef FETCH_TIMEOUT_EN
      // Only reset leaves HALT; i_run is deliberately ignored here.
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Instruction latch: written only by a FETCH-cycle ack, so stray acks in
  // later states cannot disturb the word the decoder is looking at.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      inst_q <= '0;
    end else if (inst_load) begin
      inst_q <= mem.i_mem_data;
    end
  end

  // ---------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------
  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .inc_en   (pc_inc),
    .load_en  (pc_load),
    .load_val (i_branch_tgt),
    .pc       (pc)
  );

  assign mem.o_mem_req  = mem_req;
  assign mem.o_mem_addr = pc;
  assign o_inst         = inst_q;
  assign o_pc           = pc;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Bench for inst_fetch_seq. A driver plays instruction memory and the
// branch unit; a reference model of the PC (next = branch ? target : pc+1,
// 16-bit wrap) pushes expected fetch addresses, instruction words and PC
// values into queues; a monitor on the falling edge pops and compares.
module tb_inst_fetch_seq;
  import core_pkg::*;

  localparam int          PC_W     = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          TIMEOUT  = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        branch_en = 1'b0;
  logic [15:0] branch_tgt = 16'h0000;
  logic [15:0] inst;
  logic        dec_en, alu_en, wb_en, fault;
  logic [15:0] pc;
  state_t      dbg_state;

  always #5 clk = ~clk;

  inst_fetch_seq_if #(.PC_W(PC_W)) mem_bus ();

  inst_fetch_seq #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_run        (run),
    .mem          (mem_bus),
    .o_inst       (inst),
    .o_dec_en     (dec_en),
    .o_alu_en     (alu_en),
    .o_wb_en      (wb_en),
    .i_branch_en  (branch_en),
    .i_branch_tgt (branch_tgt),
    .o_pc         (pc),
    .o_fault      (fault),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_inst_q[$];
  logic [15:0] exp_pc_q[$];
  logic [15:0] exp_cur_pc = RESET_PC;
  logic [15:0] model_pc = RESET_PC;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  bit          prev_ack, prev_dec, prev_alu, prev_wb;
  logic [15:0] cur_inst;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_ack = 1'b0;
      prev_dec = 1'b0;
      prev_alu = 1'b0;
      prev_wb  = 1'b0;
    end else begin
      check("dec_after_ack", 32'(dec_en), 32'(prev_ack));
      check("alu_after_dec", 32'(alu_en), 32'(prev_dec));
      check("wb_after_alu", 32'(wb_en), 32'(prev_alu));
      check("fault_low", 32'(fault), 32'd0);
      if (prev_wb) begin
        if (exp_pc_q.size() > 0) exp_cur_pc = exp_pc_q.pop_front();
        else fail_now("pc_queue_empty");
      end
      check("pc", 32'(pc), 32'(exp_cur_pc));
      if (mem_bus.o_mem_req) begin
        check("no_strobe_in_fetch", 32'({dec_en, alu_en, wb_en}), 32'd0);
        if (exp_addr_q.size() > 0) check("mem_addr", 32'(mem_bus.o_mem_addr), 32'(exp_addr_q[0]));
        else fail_now("unexpected_mem_req");
      end
      if (dec_en) begin
        if (exp_inst_q.size() > 0) begin
          cur_inst = exp_inst_q.pop_front();
          check("inst_at_decode", 32'(inst), 32'(cur_inst));
        end else begin
          fail_now("unexpected_dec_en");
        end
      end
      if (alu_en || wb_en) check("inst_held", 32'(inst), 32'(cur_inst));
      prev_ack = mem_bus.o_mem_req && mem_bus.i_mem_ack;
      if (prev_ack && exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
      prev_dec = dec_en;
      prev_alu = alu_en;
      prev_wb  = wb_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the sequencer is requesting; returns 0 on timeout.
  task automatic wait_req(output bit ok);
    int t = 0;
    while (!mem_bus.o_mem_req && t < 20) begin
      tick();
      t++;
    end
    ok = mem_bus.o_mem_req;
    if (!ok) fail_now("wait_for_mem_req");
  endtask

  // One instruction: ack after lat wait cycles with data, then in WRITEBACK
  // present br/tgt and leave i_run at run_after. ex_br pulses a branch in
  // EXECUTE; noise randomises branch/run/ack in DECODE and EXECUTE.
  task automatic do_instr(input int lat, input logic [15:0] data, input bit br,
                          input logic [15:0] tgt, input bit run_after,
                          input bit ex_br, input bit noise);
    bit ok;
    run = 1'b1;
    wait_req(ok);
    if (!ok) return;
    exp_addr_q.push_back(model_pc);
    repeat (lat) tick();
    mem_bus.i_mem_ack  = 1'b1;
    mem_bus.i_mem_data = data;
    exp_inst_q.push_back(data);
    tick();
    // DECODE
    mem_bus.i_mem_ack = 1'b0;
    run = run_after;
    if (noise) begin
      branch_en          = 1'($urandom_range(0, 1));
      branch_tgt         = 16'($urandom);
      mem_bus.i_mem_ack  = 1'($urandom_range(0, 1));
      mem_bus.i_mem_data = 16'($urandom);
      run                = 1'($urandom_range(0, 1));
    end
    tick();
    // EXECUTE
    branch_en  = ex_br;
    branch_tgt = 16'h0123;
    if (noise) begin
      branch_en          = 1'($urandom_range(0, 1));
      branch_tgt         = 16'($urandom);
      mem_bus.i_mem_ack  = 1'($urandom_range(0, 1));
      mem_bus.i_mem_data = 16'($urandom);
    end
    tick();
    // WRITEBACK
    mem_bus.i_mem_ack = 1'b0;
    branch_en  = br;
    branch_tgt = tgt;
    run        = run_after;
    model_pc   = br ? tgt : model_pc + 16'd1;
    exp_pc_q.push_back(model_pc);
    tick();
    branch_en = 1'b0;
  endtask

  task automatic reset_mid_fetch();
    bit ok;
    mon_en = 1'b0;
    run = 1'b1;
    wait_req(ok);
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_req", 32'(mem_bus.o_mem_req), 32'd0);
    check("rst_pc", 32'(pc), 32'(RESET_PC));
    check("rst_inst", 32'(inst), 32'd0);
    rst_n = 1'b1;
    run = 1'b0;
    mem_bus.i_mem_ack  = 1'b1;
    mem_bus.i_mem_data = 16'hBEEF;
    tick();
    mem_bus.i_mem_ack = 1'b0;
    check("late_ack_inst", 32'(inst), 32'd0);
    check("late_ack_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_addr_q.delete();
    exp_inst_q.delete();
    exp_pc_q.delete();
    model_pc   = RESET_PC;
    exp_cur_pc = RESET_PC;
    mon_en = 1'b1;
    tick();
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic timeout_test();
    bit ok;
    int n = 0;
    mon_en = 1'b0;
    run = 1'b1;
    wait_req(ok);
    while (mem_bus.o_mem_req && n < 40) begin
      check("fault_before_timeout", 32'(fault), 32'd0);
      n++;
      tick();
    end
    check("timeout_req_cycles", 32'(n), 32'(TIMEOUT));
    check("fault_set", 32'(fault), 32'd1);
    check("halt_state", 32'(dbg_state), 32'(ST_HALT));
    repeat (5) tick();
    check("halt_req_low", 32'(mem_bus.o_mem_req), 32'd0);
    check("halt_strobes", 32'({dec_en, alu_en, wb_en}), 32'd0);
    check("fault_sticky", 32'(fault), 32'd1);
    rst_n = 1'b0;
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    check("fault_cleared", 32'(fault), 32'd0);
    check("halt_exit_state", 32'(dbg_state), 32'(ST_IDLE));
    model_pc   = RESET_PC;
    exp_cur_pc = RESET_PC;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    mem_bus.i_mem_ack  = 1'b0;
    mem_bus.i_mem_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset_pc", 32'(pc), 32'(RESET_PC));
    check("reset_inst", 32'(inst), 32'd0);
    check("reset_req", 32'(mem_bus.o_mem_req), 32'd0);
    check("reset_strobes", 32'({dec_en, alu_en, wb_en}), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed cases.
    do_instr(0, 16'h1704, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); // zero wait, addr 0
    do_instr(3, 16'h2A51, 1'b1, 16'h0040, 1'b1, 1'b0, 1'b0); // 3-cycle wait, branch
    do_instr(1, 16'h3C3C, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0); // branch only in EXECUTE
    do_instr(0, 16'h4001, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0); // preload FFFF
    do_instr(2, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); // wrap, run dropped
    repeat (4) tick();
    check("idle_after_drop", 32'(dbg_state), 32'(ST_IDLE));

    // Randomised traffic.
    for (int i = 0; i < 150; i++) begin
      logic [15:0] tgt;
      bit          ra;
      tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      ra  = (i == 149) ? 1'b0 : ($urandom_range(0, 3) != 0);
      do_instr($urandom_range(0, 4), 16'($urandom), ($urandom_range(0, 3) == 0),
               tgt, ra, 1'b0, 1'b1);
      if (!ra) repeat ($urandom_range(0, 3)) tick();
    end
    repeat (3) tick();

    reset_mid_fetch();
    do_instr(1, 16'h6E6E, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

`ifdef FETCH_TIMEOUT_EN
    timeout_test();
`endif

    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    check("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);
    check("pc_queue_drained", 32'(exp_pc_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/inst_fetch_seq.md
Name: inst_fetch_seq

Overview:
- Producer side of the instruction decoder's input interface.
- Owns the PC and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction on o_inst with a one-cycle o_dec_en decode strobe, then sequences the execute and writeback enables.
- Applies branch redirects at writeback.
- Sits between instruction memory and the decoder/ALU/register file of the 16-bit RISC core.

Parameters:
- PC_W, 16, width of PC and memory address (word addressed).
- RESET_PC, 16'h0000, PC value loaded at reset.
- TIMEOUT, 16, cycles to wait for i_mem_ack before fault (optional feature only).

Ports:
- i_clk  input  1  core clock, all state on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_run  input  1  1 = sequencer may start a new fetch; 0 = park in IDLE at next instruction boundary
- o_mem_req  output  1  memory read request, held until ack
- o_mem_addr  output  PC_W  word address = current PC, stable while o_mem_req=1
- i_mem_ack  input  1  memory data valid this cycle
- i_mem_data  input  16  instruction word, sampled when i_mem_ack=1
- o_inst  output  16  latched instruction to decoder, stable from DECODE through WRITEBACK
- o_dec_en  output  1  decoder enable, high exactly one cycle per instruction
- o_alu_en  output  1  ALU enable, one cycle
- o_wb_en  output  1  register writeback enable, one cycle
- i_branch_en  input  1  take branch, sampled in WRITEBACK
- i_branch_tgt  input  PC_W  branch target word address
- o_pc  output  PC_W  current PC
- o_fault  output  1  sticky fetch fault (optional feature; tied 0 otherwise)

Behaviour:
- Reset: synchronous, active-low, sampled on rising edge of i_clk; overrides everything, including mid-fetch.
  - Reset values: state=IDLE, PC=RESET_PC, o_inst=16'h0000, o_fault=0.
  - All strobes and o_mem_req low.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT (HALT only with optional feature).
- IDLE:
  - Outputs low.
  - i_run=1 → FETCH next cycle; otherwise stay.
- FETCH:
  - o_mem_req=1, o_mem_addr=PC.
  - On the cycle i_mem_ack=1: latch i_mem_data into o_inst, → DECODE.
  - Zero-wait memory (ack in the first FETCH cycle) is legal; FETCH lasts minimum 1 cycle.
  - i_mem_ack while not in FETCH is ignored.
- DECODE:
  - o_dec_en=1 for this cycle only; o_inst holds the latched word → EXECUTE.
- EXECUTE:
  - o_alu_en=1 → WRITEBACK.
- WRITEBACK:
  - o_wb_en=1.
  - PC update: PC ← i_branch_en ? i_branch_tgt : PC+1, modulo 2^PC_W (16'hFFFF+1 = 16'h0000).
  - Next state: i_run=1 → FETCH, else → IDLE.
- Throughput: best case 4 cycles per instruction (1 FETCH + DECODE + EXECUTE + WRITEBACK).
- Strobe exclusivity: o_dec_en, o_alu_en and o_wb_en are mutually exclusive and each one-hot per instruction.
- i_run deassertion: dropping i_run mid-instruction does not abort. The instruction completes through WRITEBACK, then the block parks in IDLE.
- o_pc reflects the PC register:
  - updates on the clock edge leaving WRITEBACK;
  - constant otherwise.
- Branch timing: i_branch_en outside WRITEBACK is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - On the TIMEOUT-th consecutive cycle without ack: o_fault ← 1, o_mem_req drops next cycle, → HALT.
  - HALT holds all strobes low and ignores i_run; only reset exits.
  - o_fault is sticky until reset.
- Disabled: no counter and no HALT state; FETCH waits indefinitely; o_fault tied 0.

Decomposition:
- Shared package (core_pkg):
  - state enum (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT);
  - INST_W=16;
  - default RESET_PC.
- Sub-module pc_reg:
  - PC register with sync active-low reset to RESET_PC;
  - inputs for increment enable and load enable + target;
  - wrap handled inside.
- The FSM and the timeout counter stay in inst_fetch_seq.

Test Plan:
- Reset then i_run=1, memory acks with zero wait returning 16'h1704 at addr 0 → o_mem_addr=0, o_inst=16'h1704 in DECODE; o_dec_en/o_alu_en/o_wb_en each high exactly once on consecutive cycles; o_pc=1 after WRITEBACK; next fetch addr=1.
- Memory ack delayed 3 cycles → o_mem_req and o_mem_addr held stable 4 cycles; o_dec_en asserts the cycle after ack; no strobes during the wait.
- i_branch_en=1, i_branch_tgt=16'h0040 in WRITEBACK → next o_mem_addr=16'h0040. The same input pulsed during EXECUTE only → PC increments normally.
- Preload PC=16'hFFFF via branch, run one instruction → o_pc wraps to 16'h0000. Drop i_run during EXECUTE → instruction completes, FSM in IDLE, o_mem_req stays 0.
- i_rst_n=0 asserted while in FETCH awaiting ack → next cycle state IDLE, PC=RESET_PC, o_mem_req=0, o_inst=0. A late ack after reset has no effect.
- With FETCH_TIMEOUT_EN and TIMEOUT=16: never ack → o_fault=1 after 16 FETCH cycles, req drops, i_run ignored. Reset clears o_fault.
